ram2e_cmd_sender: RTL

- Apple IIe-side bus initiator for RAM2E command traffic.
- Generates the 14-tick auxiliary-slot bus cycle: PHI1, multiplexed Ain, nWE, nEN80, nC07X and write data.
- On request, writes the unlock sequence FF 00 55 AA C1 AD, then a command byte and an optional argument byte, to the RAMWorks bank register ($C073).
- Used for bring-up and bench exercise of the card's command detector and volatile settings (E0 mask set, E2 LED set, E3 LED get, F0 LED detect).

---
 rtl/ram2e_pkg.sv | 41 ++++
 rtl/ram2e_cmd_sender_if.sv | 15 +
 rtl/ram2e_bus_timer.sv | 46 ++++
 rtl/ram2e_cmd_sender.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ram2e_pkg.sv
// Shared constants for the Apple IIe-side RAM2E command sender: bus tick
// positions, unlock sequence, command codes and the sequencer state encoding.
package ram2e_pkg;

    localparam logic [3:0] T_PHI1_FALL = 4'd7;
    localparam logic [3:0] T_ROW       = 4'd5;
    localparam logic [3:0] T_COL       = 4'd9;
    localparam logic [3:0] T_DATA      = 4'd8;
    localparam logic [3:0] T_LAST      = 4'd13;

    localparam logic [7:0] CMD_MASK_SET   = 8'hE0;
    localparam logic [7:0] CMD_LED_SET    = 8'hE2;
    localparam logic [7:0] CMD_LED_GET    = 8'hE3;
    localparam logic [7:0] CMD_LED_DETECT = 8'hF0;

    localparam logic [2:0] UNLOCK_LEN = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT0 = 3'd1,
        ST_SEND  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Unlock sequence FF 00 55 AA C1 AD, indexed 0..5.
    function automatic logic [7:0] unlock_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hFF;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'h55;
            3'd3:    b = 8'hAA;
            3'd4:    b = 8'hC1;
            3'd5:    b = 8'hAD;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ram2e_cmd_sender_if.sv
// Request/status handshake between a command source and ram2e_cmd_sender.
interface ram2e_cmd_sender_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       cmd_has_arg;
    logic       busy;
    logic       done;

    modport master (output cmd_valid, cmd_code, cmd_arg, cmd_has_arg,
                    input  cmd_ready, busy, done);
    modport slave  (input  cmd_valid, cmd_code, cmd_arg, cmd_has_arg,
                    output cmd_ready, busy, done);
endinterface

// File: rtl/ram2e_bus_timer.sv
// 14-tick Apple IIe bus cycle timer: owns T and PHI1 and decodes bus phases.
// Phase decodes describe the NEXT tick so callers can register their pins.
module ram2e_bus_timer
    import ram2e_pkg::*;
(
    input  logic C14M,
    input  logic Reset,
    output logic phi1,
    output logic is_last,
    output logic row_phase,
    output logic col_phase,
    output logic data_phase,
    output logic strobe_phase
);

    logic [3:0] t_r;
    logic [3:0] t_nxt_s;

    // Next tick value with wrap at T_LAST.
    always_comb begin
        t_nxt_s = 4'd0;
        if (t_r == T_LAST) begin
            t_nxt_s = 4'd0;
        end else begin
            t_nxt_s = t_r + 4'd1;
        end
    end

    // Tick counter and PHI1, free-running including while idle.
    always_ff @(posedge C14M) begin
        if (Reset) begin
            t_r  <= 4'd0;
            phi1 <= 1'b1;
        end else begin
            t_r  <= t_nxt_s;
            phi1 <= (t_nxt_s < T_PHI1_FALL);
        end
    end

    assign is_last      = (t_r == T_LAST);
    assign row_phase    = (t_nxt_s >= T_ROW) && (t_nxt_s < T_COL);
    assign col_phase    = (t_nxt_s >= T_COL);
    assign data_phase   = (t_nxt_s >= T_DATA);
    assign strobe_phase = (t_nxt_s >= T_PHI1_FALL);

endmodule

// File: rtl/ram2e_cmd_sender.sv
// Bus initiator that writes the RAM2E unlock sequence plus a command byte and
// optional argument to the RAMWorks bank register, one write per bus cycle.
module ram2e_cmd_sender
    import ram2e_pkg::*;
#(
    parameter logic [7:0] ROW_ADDR   = 8'h73,
    parameter logic [7:0] COL_ADDR   = 8'hC0,
    parameter int         GAP_CYCLES = 0
) (
    input  logic               C14M,
    input  logic               Reset,
    ram2e_cmd_sender_if.slave  cmd,
    output logic               PHI1,
    output logic [7:0]         Ain,
    output logic               nWE,
    output logic               nEN80,
    output logic               nC07X,
    output logic [7:0]         Dout,
    output logic               Dout_oe
);

    if (ROW_ADDR[0] != 1'b1 || ROW_ADDR[3] != 1'b0) begin : g_bad_row_addr
        $error("ram2e_cmd_sender: ROW_ADDR needs bit0=1 and bit3=0");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 6) begin : g_bad_gap
        $error("ram2e_cmd_sender: GAP_CYCLES must be 0..6");
    end

    localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

    state_t     state_r;
    logic [2:0] idx_r;
    logic [2:0] gap_cnt_r;
    logic [7:0] code_r;
    logic [7:0] arg_r;
    logic       has_arg_r;
    logic       is_last_s;
    logic       row_s;
    logic       col_s;
    logic       data_s;
    logic       strobe_s;
    logic       last_byte_s;
    logic       write_s;
    logic [7:0] byte_s;

    ram2e_bus_timer u_timer (
        .C14M         (C14M),
        .Reset        (Reset),
        .phi1         (PHI1),
        .is_last      (is_last_s),
        .row_phase    (row_s),
        .col_phase    (col_s),
        .data_phase   (data_s),
        .strobe_phase (strobe_s)
    );

    assign last_byte_s = (idx_r == 3'd7) || ((idx_r == 3'd6) && !has_arg_r);
    // SEND only changes at T_LAST, so it is valid for every look-ahead tick.
    assign write_s     = (state_r == ST_SEND);

    // Byte for the current write slot.
    always_comb begin
        byte_s = 8'h00;
        case (idx_r)
            3'd6:    byte_s = code_r;
            3'd7:    byte_s = arg_r;
            default: byte_s = unlock_byte(idx_r);
        endcase
    end

    // Request sequencer with registered handshake outputs.
    always_ff @(posedge C14M) begin
        if (Reset) begin
            state_r       <= ST_IDLE;
            idx_r         <= 3'd0;
            gap_cnt_r     <= 3'd0;
            code_r        <= 8'h00;
            arg_r         <= 8'h00;
            has_arg_r     <= 1'b0;
            cmd.cmd_ready <= 1'b1;
            cmd.busy      <= 1'b0;
            cmd.done      <= 1'b0;
        end else begin
            cmd.done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        code_r        <= cmd.cmd_code;
                        arg_r         <= cmd.cmd_arg;
                        has_arg_r     <= cmd.cmd_has_arg;
                        idx_r         <= 3'd0;
                        gap_cnt_r     <= 3'd0;
                        cmd.cmd_ready <= 1'b0;
                        cmd.busy      <= 1'b1;
                        // Accepting on the last tick already lands on T=0.
                        state_r       <= is_last_s ? ST_SEND : ST_WAIT0;
                    end
                end
                ST_WAIT0: begin
                    if (is_last_s) begin
                        state_r <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (is_last_s) begin
                        if (last_byte_s) begin
                            state_r  <= ST_DONE;
                            cmd.done <= 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= 3'd0;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (is_last_s) begin
                        if (gap_cnt_r == GAP_LAST) begin
                            state_r <= ST_SEND;
                            idx_r   <= idx_r + 3'd1;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r       <= ST_IDLE;
                    cmd.cmd_ready <= 1'b1;
                    cmd.busy      <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cmd.cmd_ready <= 1'b1;
                    cmd.busy      <= 1'b0;
                end
            endcase
        end
    end

    // Registered bus pins, driven from the look-ahead phase decodes.
    always_ff @(posedge C14M) begin
        if (Reset) begin
            Ain     <= 8'h00;
            nWE     <= 1'b1;
            nEN80   <= 1'b1;
            nC07X   <= 1'b1;
            Dout    <= 8'h00;
            Dout_oe <= 1'b0;
        end else begin
            Ain     <= (write_s && row_s) ? ROW_ADDR :
                       (write_s && col_s) ? COL_ADDR : 8'h00;
            nWE     <= !(write_s && strobe_s);
            nEN80   <= !(write_s && strobe_s);
            nC07X   <= !(write_s && strobe_s);
            Dout    <= (write_s && data_s) ? byte_s : 8'h00;
            Dout_oe <= write_s && data_s;
        end
    end

endmodule
